mc_mem_unit: RTL and testbench

//  Unified instruction/data memory stage of the multicycle MIPS datapath; directly consumes the

---
 rtl/mc_mem_unit.sv | 123 ++++++++++++
 tb/tb_mc_mem_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_unit.sv
// Unified instruction/data memory stage for a multicycle MIPS datapath.
// A request is accepted in IDLE, completes after a fixed latency, and then pulses done for one cycle.
module mc_mem_unit #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        IorD,
  input  logic        IR_write,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] wdata,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_e;

  state_e      state_q;
  logic [2:0]  count_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ir_write_q;
  logic [31:0] ir_q;
  logic [31:0] mdr_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH];

  logic          addr_bad;
  logic [AW-1:0] word_idx;
  logic          rd_last;
  logic          wr_last;

  // Address checks use the captured address, so inputs may change freely while busy.
  assign addr_bad = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  assign word_idx = addr_q[AW+1:2];
  assign rd_last  = (state_q == RD_WAIT) && (count_q == 3'(RD_LAT));
  assign wr_last  = (state_q == WR_WAIT) && (count_q == 3'(WR_LAT));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      ir_write_q <= 1'b0;
      ir_q       <= 32'd0;
      mdr_q      <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (memwrite || memread) begin
            addr_q     <= IorD ? alu_out : pc;
            ir_write_q <= IR_write;
            wdata_q    <= wdata;
            count_q    <= 3'd1;
            busy_q     <= 1'b1;
            // A simultaneous read and write request is treated as a write only.
            state_q    <= memwrite ? WR_WAIT : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_last) begin
            if (!addr_bad) begin
              if (ir_write_q) ir_q  <= mem_q[word_idx];
              else            mdr_q <= mem_q[word_idx];
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= addr_bad;
            state_q <= DONE;
          end else begin
            count_q <= count_q + 3'd1;
          end
        end
        WR_WAIT: begin
          if (wr_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= addr_bad;
            state_q <= DONE;
          end else begin
            count_q <= count_q + 3'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; clearing it would force a flop-based memory.
  // An aborted write is suppressed because state_q is already IDLE under reset.
  always_ff @(posedge clk) begin
    if (wr_last && !addr_bad) mem_q[word_idx] <= wdata_q;
  end

  assign ir       = ir_q;
  assign mdr      = mdr_q;
  assign mem_busy = busy_q;
  assign mem_done = done_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_mc_mem_unit.sv
// Self-checking bench for mc_mem_unit: directed vector table, reset-abort sequences,
// and randomized accesses checked against a word-array reference model.
module tb_mc_mem_unit;

  localparam int DEPTH  = 64;
  localparam int RD_LAT = 3;
  localparam int WR_LAT = 2;

  logic        clk;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic        IorD;
  logic        IR_write;
  logic [31:0] pc;
  logic [31:0] alu_out;
  logic [31:0] wdata;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic        mem_busy;
  logic        mem_done;
  logic        addr_err;

  mc_mem_unit #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .memread  (memread),
    .memwrite (memwrite),
    .IorD     (IorD),
    .IR_write (IR_write),
    .pc       (pc),
    .alu_out  (alu_out),
    .wdata    (wdata),
    .ir       (ir),
    .mdr      (mdr),
    .mem_busy (mem_busy),
    .mem_done (mem_done),
    .addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: word array plus the two architectural registers.
  logic [31:0] mem_m [DEPTH];
  logic [31:0] ir_m;
  logic [31:0] mdr_m;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        iord;
    logic        irw;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] exp_ir;
    logic [31:0] exp_mdr;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic rd, input logic wr, input logic iord, input logic irw,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] wd,
                       output logic err);
    logic [31:0] ad;
    int          w;
    ad  = iord ? a : p;
    w   = int'(ad / 4);
    err = (ad % 4 != 0) || (ad / 4 >= DEPTH);
    if (wr) begin
      if (!err) mem_m[w] = wd;
    end else if (rd && !err) begin
      if (irw) ir_m = mem_m[w];
      else     mdr_m = mem_m[w];
    end
  endtask

  // One complete access; inputs are scrambled while busy to show they are ignored.
  task automatic access(input logic rd, input logic wr, input logic iord, input logic irw,
                        input logic [31:0] p, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] ir_a, output logic [31:0] mdr_a,
                        output logic err_a);
    int n;
    int lat;
    lat = wr ? WR_LAT : RD_LAT;
    @(negedge clk);
    memread  = rd;
    memwrite = wr;
    IorD     = iord;
    IR_write = irw;
    pc       = p;
    alu_out  = a;
    wdata    = wd;
    @(posedge clk);
    #1;
    check("busy_after_accept", {31'd0, mem_busy}, 32'd1);
    n = 0;
    do begin
      memread  = 1'($urandom);
      memwrite = 1'($urandom);
      IorD     = 1'($urandom);
      IR_write = 1'($urandom);
      pc       = $urandom;
      alu_out  = $urandom;
      wdata    = $urandom;
      @(posedge clk);
      #1;
      n++;
      if (!mem_done && n < lat) check("busy_while_waiting", {31'd0, mem_busy}, 32'd1);
    end while (!mem_done && n < 20);
    memread  = 1'b0;
    memwrite = 1'b0;
    check("done_latency", 32'(n), 32'(lat));
    check("busy_in_done", {31'd0, mem_busy}, 32'd0);
    ir_a  = ir;
    mdr_a = mdr;
    err_a = addr_err;
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, mem_done}, 32'd0);
    check("err_one_cycle", {31'd0, addr_err}, 32'd0);
  endtask

  // Accept a request, let one edge pass, then pull reset asynchronously.
  task automatic abort_access(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    memread  = ~wr;
    memwrite = wr;
    IorD     = 1'b1;
    IR_write = 1'b1;
    alu_out  = a;
    wdata    = wd;
    @(posedge clk);
    #1;
    memread  = 1'b0;
    memwrite = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_ir", ir, 32'd0);
    check("abort_mdr", mdr, 32'd0);
    check("abort_busy", {31'd0, mem_busy}, 32'd0);
    check("abort_done", {31'd0, mem_done}, 32'd0);
    ir_m  = 32'd0;
    mdr_m = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("post_abort_quiet", {ir[31:1], ir[0] | mem_done | mem_busy}, 32'd0);
    end
  endtask

  vec_t        vt [15];
  logic [31:0] ir_a;
  logic [31:0] mdr_a;
  logic        err_a;
  logic        err_m;

  initial begin
    vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h8,   32'h2008_0005, 32'h0,          32'h0,          1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8,   32'h44,  32'h0,         32'h2008_0005, 32'h0,          1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h40,  32'hDEAD_BEEF, 32'h2008_0005, 32'h0,          1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h8,   32'h40,  32'h0,         32'h2008_0005, 32'hDEAD_BEEF, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8,   32'h10,  32'h1234,      32'h2008_0005, 32'hDEAD_BEEF, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h10,  32'h0,         32'h2008_0005, 32'h1234,      1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,   32'h1111_0000, 32'h2008_0005, 32'h1234,      1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h42,  32'h0BAD_0BAD, 32'h2008_0005, 32'h1234,      1'b1};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h42,  32'h0,         32'h2008_0005, 32'h1234,      1'b1};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h100, 32'h0BAD_0BAD, 32'h2008_0005, 32'h1234,      1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0,   32'h100, 32'h0,         32'h2008_0005, 32'h1234,      1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h8,   32'h0,   32'h0,         32'h1111_0000, 32'h1234,      1'b0};
    vt[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h8,   32'h40,  32'h0,         32'h1111_0000, 32'hDEAD_BEEF, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8,   32'h0,   32'h0,         32'h2008_0005, 32'hDEAD_BEEF, 1'b0};
    vt[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 32'h8,   32'h0,         32'h2008_0005, 32'hDEAD_BEEF, 1'b1};

    reset    = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    IorD     = 1'b0;
    IR_write = 1'b0;
    pc       = 32'd0;
    alu_out  = 32'd0;
    wdata    = 32'd0;
    ir_m     = 32'd0;
    mdr_m    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ir", ir, 32'd0);
    check("reset_mdr", mdr, 32'd0);
    check("reset_flags", {29'd0, mem_busy, mem_done, addr_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      access(vt[i].rd, vt[i].wr, vt[i].iord, vt[i].irw, vt[i].pc, vt[i].alu, vt[i].wd,
             ir_a, mdr_a, err_a);
      model(vt[i].rd, vt[i].wr, vt[i].iord, vt[i].irw, vt[i].pc, vt[i].alu, vt[i].wd, err_m);
      check($sformatf("vec%0d_ir", i), ir_a, vt[i].exp_ir);
      check($sformatf("vec%0d_mdr", i), mdr_a, vt[i].exp_mdr);
      check($sformatf("vec%0d_err", i), {31'd0, err_a}, {31'd0, vt[i].exp_err});
    end

    for (int w = 0; w < DEPTH; w++) begin
      logic [31:0] v;
      v = $urandom;
      access(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'(w * 4), v, ir_a, mdr_a, err_a);
      model(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'(w * 4), v, err_m);
    end

    for (int i = 0; i < 300; i++) begin
      logic        rd, wr, iord, irw;
      logic [31:0] ad, p, a, wd;
      int          kind;
      kind = int'($urandom_range(0, 9));
      wr   = ($urandom_range(0, 9) < 4);
      rd   = !wr || ($urandom_range(0, 3) == 0);
      iord = 1'($urandom);
      irw  = 1'($urandom);
      ad   = 32'($urandom_range(0, DEPTH - 1) * 4);
      if (kind == 0) ad = ad + 32'($urandom_range(1, 3));
      if (kind == 1) ad = ad + 32'(DEPTH * 4) * 32'($urandom_range(1, 1000));
      p    = iord ? $urandom : ad;
      a    = iord ? ad : $urandom;
      wd   = $urandom;
      access(rd, wr, iord, irw, p, a, wd, ir_a, mdr_a, err_a);
      model(rd, wr, iord, irw, p, a, wd, err_m);
      check("rnd_ir", ir_a, ir_m);
      check("rnd_mdr", mdr_a, mdr_m);
      check("rnd_err", {31'd0, err_a}, {31'd0, err_m});
    end

    abort_access(1'b0, 32'h14, 32'h0);
    access(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h14, 32'h0, ir_a, mdr_a, err_a);
    model(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h14, 32'h0, err_m);
    check("after_rd_abort_ir", ir_a, ir_m);
    check("after_rd_abort_mdr", mdr_a, 32'd0);

    abort_access(1'b1, 32'h18, 32'hCAFE_F00D);
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h18, 32'h0, ir_a, mdr_a, err_a);
    model(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h18, 32'h0, err_m);
    check("after_wr_abort_mdr", mdr_a, mdr_m);
    check("after_wr_abort_ir", ir_a, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
